// File: rtl/conv1_wm_loader.sv
// conv1 weight-memory write feeder: packs IN_WIDTH beats into OUT_WIDTH words on RAM port A.
// Optional beat checksum accumulator enabled by defining CONV1_WM_LOADER_CKSUM_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, s_ready low
// S_LOAD  | accepting beats, writing one word per R beats
// S_FLUSH | final word being written (or empty load), s_ready low
// S_DONE  | done pulse, returns to S_IDLE
module conv1_wm_loader #(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 512,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 242
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic                  s_last,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [OUT_WIDTH-1:0]  dina,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IN_WIDTH-1:0]   cksum
);

    localparam int R      = OUT_WIDTH / IN_WIDTH;
    localparam int BEAT_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(R - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t                state;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [ADDR_WIDTH:0]   n_words;
    logic [OUT_WIDTH-1:0]  word_buf;
    logic [OUT_WIDTH-1:0]  packed_word;
    logic [ADDR_WIDTH:0]   n_clamp;
    logic                  last_word;
    logic                  final_beat;
    logic                  accept;

    // Right shift so that after R beats the first beat sits in the LSBs.
    assign packed_word = {s_data, word_buf[OUT_WIDTH-1:IN_WIDTH]};
    assign n_clamp     = (num_words > DEPTH_W) ? DEPTH_W : num_words;
    assign last_word   = (word_idx == n_words - 1'b1);
    assign final_beat  = last_word && (beat_cnt == BEAT_LAST);
    assign accept      = (state == S_LOAD) && s_valid && s_ready;

    always_ff @(posedge clka) begin
        if (rsta) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            word_idx <= '0;
            n_words  <= '0;
            word_buf <= '0;
            s_ready  <= 1'b0;
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wea  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err      <= (num_words > DEPTH_W);
                        n_words  <= n_clamp;
                        word_idx <= '0;
                        beat_cnt <= '0;
                        word_buf <= '0;
                        busy     <= 1'b1;
                        if (n_clamp == '0) begin
                            state <= S_FLUSH;
                        end else begin
                            state   <= S_LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        word_buf <= packed_word;
                        if (s_last != final_beat)
                            err <= 1'b1;
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            wea      <= 1'b1;
                            addra    <= word_idx[ADDR_WIDTH-1:0];
                            dina     <= packed_word;
                            word_idx <= word_idx + 1'b1;
                            if (last_word) begin
                                s_ready <= 1'b0;
                                state   <= S_FLUSH;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV1_WM_LOADER_CKSUM_EN
    logic [IN_WIDTH-1:0] cksum_q;

    always_ff @(posedge clka) begin
        if (rsta)
            cksum_q <= '0;
        else if (state == S_IDLE && start)
            cksum_q <= '0;
        else if (accept)
            cksum_q <= cksum_q ^ s_data;
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_conv1_wm_loader.sv
// Directed self-checking bench for conv1_wm_loader at default parameters.
module tb_conv1_wm_loader;

    logic         clk;
    logic         rsta;
    logic         start;
    logic [8:0]   num_words;
    logic         s_valid;
    logic         s_ready;
    logic [63:0]  s_data;
    logic         s_last;
    logic         wea;
    logic [7:0]   addra;
    logic [511:0] dina;
    logic         busy;
    logic         done;
    logic         err;
    logic [63:0]  cksum;

    conv1_wm_loader dut (
        .clka      (clk),
        .rsta      (rsta),
        .start     (start),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cksum     (cksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int           cyc_cnt = 0;
    int           wcount = 0;
    int           wea_runs = 0;
    int           done_count = 0;
    int           done_cyc = -1;
    int           last_wea_cyc = -1;
    logic         prev_wea = 1'b0;
    logic [63:0]  done_cksum = '0;
    logic [7:0]   wq_addr[$];
    logic [511:0] wq_data[$];

    int start_cyc;
    int last_acc;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (wea) begin
            wq_addr.push_back(addra);
            wq_data.push_back(dina);
            wcount++;
            last_wea_cyc = cyc_cnt;
            if (prev_wea) wea_runs++;
        end
        prev_wea = wea;
        if (done) begin
            done_count++;
            done_cyc   = cyc_cnt;
            done_cksum = cksum;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        wcount = 0;
        wea_runs = 0;
        done_count = 0;
        done_cyc = -1;
        last_wea_cyc = -1;
    endtask

    task automatic do_reset();
        rsta = 1'b1;
        repeat (2) @(posedge clk);
        #1 rsta = 1'b0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_words = 9'(n);
        @(negedge clk);
        start_cyc = cyc_cnt;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: data = base + beat index; mode 1: data = 1 << beat index
    task automatic drive(input int nbeats, input int last_idx, input bit throttle,
                         input bit mode, input int base);
        int i = 0;
        int c = 0;
        logic acc;
        while (i < nbeats && c < nbeats * 4 + 20) begin
            s_valid = throttle ? (c % 2 == 0) : 1'b1;
            s_data  = mode ? (64'd1 << i) : 64'(base + i);
            s_last  = (i == last_idx);
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) last_acc = cyc_cnt;
            @(posedge clk);
            #1;
            if (acc) i++;
            c++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        check("beats_accepted", 512'(i), 512'(nbeats));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [511:0] exp_word;
    logic [63:0]  exp_ck;
    int bad_addr;
    int bad_data;

    initial begin
        rsta = 1'b0; start = 1'b0; num_words = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        last_acc = 0; start_cyc = 0;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_s_ready", 512'(s_ready), 512'(0));
        check("rst_wea",     512'(wea),     512'(0));
        check("rst_addra",   512'(addra),   512'(0));
        check("rst_dina",    dina,          512'(0));
        check("rst_busy",    512'(busy),    512'(0));
        check("rst_done",    512'(done),    512'(0));
        check("rst_err",     512'(err),     512'(0));
        check("rst_cksum",   512'(cksum),   512'(0));
        @(posedge clk); #1;

        // nominal two-word load
        clear_mon();
        do_start(2);
        @(negedge clk);
        check("nom_ready_t1", 512'(s_ready), 512'(1));
        check("nom_busy_t1",  512'(busy),    512'(1));
        @(posedge clk); #1;
        drive(16, 15, 1'b0, 1'b0, 0);
        idle_cycles(5);
        for (int k = 0; k < 8; k++) exp_word[k*64 +: 64] = 64'(k);
        check("nom_wcount", 512'(wcount), 512'(2));
        if (wcount == 2) begin
            check("nom_addr0", 512'(wq_addr[0]), 512'(0));
            check("nom_data0", wq_data[0], exp_word);
            check("nom_data0_top", 512'(wq_data[0][511:448]), 512'(7));
            check("nom_addr1", 512'(wq_addr[1]), 512'(1));
            check("nom_data1_lo", 512'(wq_data[1][63:0]), 512'(8));
        end
        check("nom_wea_cyc",  512'(last_wea_cyc), 512'(last_acc + 1));
        check("nom_done_cyc", 512'(done_cyc),     512'(last_acc + 2));
        check("nom_done_cnt", 512'(done_count),   512'(1));
        check("nom_err",      512'(err),          512'(0));
        check("nom_busy_end", 512'(busy),         512'(0));
        check("nom_ready_end",512'(s_ready),      512'(0));

        // throttled input
        clear_mon();
        do_start(2);
        drive(16, 15, 1'b1, 1'b0, 0);
        idle_cycles(5);
        check("thr_wcount", 512'(wcount), 512'(2));
        if (wcount == 2) begin
            check("thr_data0", wq_data[0], exp_word);
            check("thr_addr1", 512'(wq_addr[1]), 512'(1));
            check("thr_data1_top", 512'(wq_data[1][511:448]), 512'(15));
        end
        check("thr_wea_runs", 512'(wea_runs), 512'(0));
        check("thr_done_cyc", 512'(done_cyc), 512'(last_acc + 2));
        check("thr_err",      512'(err),      512'(0));

        // length clamp: 300 requested, 242 written
        clear_mon();
        do_start(300);
        drive(242 * 8, 242 * 8 - 1, 1'b0, 1'b0, 0);
        idle_cycles(5);
        check("clamp_wcount", 512'(wcount), 512'(242));
        bad_addr = 0;
        bad_data = 0;
        for (int w = 0; w < wcount && w < 242; w++) begin
            if (wq_addr[w] != 8'(w)) bad_addr++;
            if (wq_data[w][63:0] != 64'(w * 8) || wq_data[w][511:448] != 64'(w * 8 + 7)) bad_data++;
        end
        check("clamp_bad_addr", 512'(bad_addr), 512'(0));
        check("clamp_bad_data", 512'(bad_data), 512'(0));
        check("clamp_last_addr", 512'(addra), 512'(241));
        check("clamp_err",      512'(err),    512'(1));
        check("clamp_done_cnt", 512'(done_count), 512'(1));

        // empty load
        clear_mon();
        do_start(0);
        idle_cycles(5);
        check("empty_done_cyc", 512'(done_cyc),   512'(start_cyc + 2));
        check("empty_done_cnt", 512'(done_count), 512'(1));
        check("empty_wcount",   512'(wcount),     512'(0));
        check("empty_err_clr",  512'(err),        512'(0));
        check("empty_addra_hold", 512'(addra),    512'(241));

        // framing error: s_last on beat 3 of a one-word load
        clear_mon();
        do_start(1);
        drive(8, 3, 1'b0, 1'b0, 0);
        idle_cycles(5);
        check("frm_wcount", 512'(wcount), 512'(1));
        if (wcount == 1) check("frm_addr0", 512'(wq_addr[0]), 512'(0));
        check("frm_wea_cyc",  512'(last_wea_cyc), 512'(last_acc + 1));
        check("frm_err",      512'(err),          512'(1));
        check("frm_done_cnt", 512'(done_count),   512'(1));

        // reset in the middle of word 0, then a clean load
        clear_mon();
        do_start(1);
        drive(5, -1, 1'b0, 1'b0, 0);
        rsta = 1'b1;
        @(posedge clk); #1;
        rsta = 1'b0;
        idle_cycles(4);
        check("rst_mid_wcount", 512'(wcount),     512'(0));
        check("rst_mid_done",   512'(done_count), 512'(0));
        check("rst_mid_busy",   512'(busy),       512'(0));
        check("rst_mid_ready",  512'(s_ready),    512'(0));
        clear_mon();
        do_start(1);
        drive(8, 7, 1'b0, 1'b0, 256);
        idle_cycles(5);
        check("rst_new_wcount", 512'(wcount), 512'(1));
        if (wcount == 1) begin
            check("rst_new_addr", 512'(wq_addr[0]), 512'(0));
            check("rst_new_lo",   512'(wq_data[0][63:0]),    512'(256));
            check("rst_new_hi",   512'(wq_data[0][511:448]), 512'(263));
        end
        check("rst_new_err",  512'(err),        512'(0));
        check("rst_new_done", 512'(done_count), 512'(1));

        // checksum over one-hot beats
        clear_mon();
        do_start(1);
        drive(8, 7, 1'b0, 1'b1, 0);
        idle_cycles(5);
`ifdef CONV1_WM_LOADER_CKSUM_EN
        exp_ck = 64'hFF;
`else
        exp_ck = 64'h0;
`endif
        check("ck_done",  512'(done_cksum), 512'(exp_ck));
        check("ck_after", 512'(cksum),      512'(exp_ck));
        if (wcount == 1) check("ck_data_lo", 512'(wq_data[0][63:0]), 512'(1));
        check("ck_err", 512'(err), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
